// File: rtl/sync_fifo_ctrl_if.sv
// Bus bundle for sync_fifo_ctrl: write/read requests, data, occupancy and status flags.
interface sync_fifo_ctrl_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 4
);
   logic              wr;
   logic [DATA_W-1:0] data_in;
   logic              rd;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              flag_clr;
   logic [ADDR_W:0]   count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              almost_full;
   logic              almost_empty;
   logic              fifo_overflow;
   logic              fifo_underflow;

   // Producer/consumer side drives requests and observes status.
   modport master (
      output wr, data_in, rd, flag_clr,
      input  data_out, rd_valid, count, fifo_full, fifo_empty,
      input  almost_full, almost_empty, fifo_overflow, fifo_underflow
   );

   // FIFO side.
   modport slave (
      input  wr, data_in, rd, flag_clr,
      output data_out, rd_valid, count, fifo_full, fifo_empty,
      output almost_full, almost_empty, fifo_overflow, fifo_underflow
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered occupancy count, almost-full/almost-empty levels,
// sticky overflow/underflow flags and a selectable registered or fall-through read port.
module sync_fifo_ctrl #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned AF_LEVEL = (2 ** ADDR_W) - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter bit          FWFT     = 1'b0
) (
   input logic             i_clk,
   input logic             i_rst_n,
   sync_fifo_ctrl_if.slave io_bus
);

   localparam int unsigned     DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_AF    = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] CNT_AE    = (ADDR_W + 1)'(AE_LEVEL);
   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [ADDR_W:0] r_wptr;
   logic [ADDR_W:0] r_rptr;
   logic [ADDR_W:0] r_count;
   logic [ADDR_W:0] w_count_nxt;
   logic            r_ovf;
   logic            r_unf;
   logic            w_ovf_nxt;
   logic            w_unf_nxt;
   logic            w_full;
   logic            w_empty;
   logic            w_rd_acc;
   logic            w_wr_acc;

   assign w_full   = (r_count == CNT_DEPTH);
   assign w_empty  = (r_count == '0);
   assign w_rd_acc = io_bus.rd & ~w_empty;
   // A write into a full FIFO still lands when the same cycle frees a slot.
   assign w_wr_acc = io_bus.wr & (~w_full | w_rd_acc);

   // Next occupancy and next sticky-flag values; a set request beats flag_clr.
   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + CNT_ONE;
      end else if (w_rd_acc && !w_wr_acc) begin
         w_count_nxt = r_count - CNT_ONE;
      end

      w_ovf_nxt = r_ovf;
      if (io_bus.wr && !w_wr_acc) begin
         w_ovf_nxt = 1'b1;
      end else if (io_bus.flag_clr) begin
         w_ovf_nxt = 1'b0;
      end

      w_unf_nxt = r_unf;
      if (io_bus.rd && !w_rd_acc) begin
         w_unf_nxt = 1'b1;
      end else if (io_bus.flag_clr) begin
         w_unf_nxt = 1'b0;
      end
   end

   // Pointer, occupancy and sticky-flag state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wptr <= r_wptr + CNT_ONE;
         end
         if (w_rd_acc) begin
            r_rptr <= r_rptr + CNT_ONE;
         end
         r_count <= w_count_nxt;
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
      end
   end

   // Storage array; deliberately not reset, pointers define what is live.
   always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wptr[ADDR_W-1:0]] <= io_bus.data_in;
      end
   end

   if (FWFT) begin : g_fwft
      // Head of queue is presented directly; content is meaningless while empty.
      assign io_bus.data_out = r_mem[r_rptr[ADDR_W-1:0]];
      assign io_bus.rd_valid = ~w_empty;
   end else begin : g_reg_rd
      logic [DATA_W-1:0] r_dout;
      logic              r_rd_valid;

      // Registered read: capture head on an accepted read, hold otherwise.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
               r_dout <= r_mem[r_rptr[ADDR_W-1:0]];
            end
         end
      end

      assign io_bus.data_out = r_dout;
      assign io_bus.rd_valid = r_rd_valid;
   end

   assign io_bus.count          = r_count;
   assign io_bus.fifo_full      = w_full;
   assign io_bus.fifo_empty     = w_empty;
   assign io_bus.almost_full    = (r_count >= CNT_AF);
   assign io_bus.almost_empty   = (r_count <= CNT_AE);
   assign io_bus.fifo_overflow  = r_ovf;
   assign io_bus.fifo_underflow = r_unf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a registered-read and a fall-through instance receive identical
// stimulus and are compared against a queue-based model of the FIFO.
module tb_sync_fifo_ctrl;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 4;

   logic clk;
   logic rst_n;

   sync_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if_reg ();
   sync_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if_ft ();

   sync_fifo_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)
   ) u_reg (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_bus (if_reg.slave)
   );

   sync_fifo_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)
   ) u_ft (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_bus (if_ft.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed status: {count, full, empty, almost_full, almost_empty, overflow, underflow}
   wire [10:0] st_reg = {if_reg.count, if_reg.fifo_full, if_reg.fifo_empty, if_reg.almost_full,
                         if_reg.almost_empty, if_reg.fifo_overflow, if_reg.fifo_underflow};
   wire [10:0] st_ft  = {if_ft.count, if_ft.fifo_full, if_ft.fifo_empty, if_ft.almost_full,
                         if_ft.almost_empty, if_ft.fifo_overflow, if_ft.fifo_underflow};

   // Reference model
   logic [DW-1:0] q[$];
   bit            ovf_m;
   bit            unf_m;
   logic [DW-1:0] dout0_m;
   bit            vld0_m;

   int errors = 0;
   int checks = 0;

   function automatic logic [10:0] exp_status();
      logic [4:0] c;
      c = 5'(q.size());
      return {c, c == 5'd16, c == 5'd0, c >= 5'd14, c <= 5'd2, ovf_m, unf_m};
   endfunction

   task automatic model_reset();
      q.delete();
      ovf_m   = 1'b0;
      unf_m   = 1'b0;
      dout0_m = '0;
      vld0_m  = 1'b0;
   endtask

   // Drive one cycle of requests into both instances and advance the model across the edge.
   task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
      bit rok;
      bit wok;
      if_reg.wr = wr; if_reg.data_in = d; if_reg.rd = rd; if_reg.flag_clr = clr;
      if_ft.wr  = wr; if_ft.data_in  = d; if_ft.rd  = rd; if_ft.flag_clr  = clr;
      @(posedge clk);
      rok = rd && (q.size() != 0);
      wok = wr && ((q.size() < 16) || rok);
      vld0_m = rok;
      if (rok) dout0_m = q.pop_front();
      if (wok) q.push_back(d);
      ovf_m = (wr && !wok) ? 1'b1 : (clr ? 1'b0 : ovf_m);
      unf_m = (rd && !rok) ? 1'b1 : (clr ? 1'b0 : unf_m);
      #1;
      if_reg.wr = 1'b0; if_reg.rd = 1'b0; if_reg.flag_clr = 1'b0;
      if_ft.wr  = 1'b0; if_ft.rd  = 1'b0; if_ft.flag_clr  = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (st_reg !== 11'b00000_0_1_0_1_0_0) begin
         errors++; $display("FAIL reset_status_reg: got %b want %b", st_reg, 11'b00000_0_1_0_1_0_0);
      end
      checks++;
      if (st_ft !== 11'b00000_0_1_0_1_0_0) begin
         errors++; $display("FAIL reset_status_ft: got %b want %b", st_ft, 11'b00000_0_1_0_1_0_0);
      end
      checks++;
      if (if_reg.rd_valid !== 1'b0) begin
         errors++; $display("FAIL reset_rd_valid_reg: got %b want 0", if_reg.rd_valid);
      end
      checks++;
      if (if_reg.data_out !== 64'h0) begin
         errors++; $display("FAIL reset_data_out_reg: got %h want 0", if_reg.data_out);
      end
      checks++;
      if (if_ft.rd_valid !== 1'b0) begin
         errors++; $display("FAIL reset_rd_valid_ft: got %b want 0", if_ft.rd_valid);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
         checks++;
         if (st_reg !== exp_status()) begin
            errors++; $display("FAIL fill_status_reg[%0d]: got %b want %b", i, st_reg, exp_status());
         end
         checks++;
         if (st_ft !== exp_status()) begin
            errors++; $display("FAIL fill_status_ft[%0d]: got %b want %b", i, st_ft, exp_status());
         end
      end
      checks++;
      if (if_reg.fifo_overflow !== 1'b1 || if_reg.count !== 5'd16) begin
         errors++;
         $display("FAIL fill_overflow: got ovf=%b count=%0d want ovf=1 count=16",
                  if_reg.fifo_overflow, if_reg.count);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (if_ft.data_out !== 64'h100 + 64'(i)) begin
            errors++; $display("FAIL fill_ft_head[%0d]: got %h want %h", i, if_ft.data_out,
                               64'h100 + 64'(i));
         end
         step(1'b0, '0, 1'b1, 1'b0);
         checks++;
         if (if_reg.rd_valid !== 1'b1 || if_reg.data_out !== 64'h100 + 64'(i)) begin
            errors++; $display("FAIL fill_read[%0d]: got v=%b d=%h want v=1 d=%h", i,
                               if_reg.rd_valid, if_reg.data_out, 64'h100 + 64'(i));
         end
      end
      step(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (if_reg.rd_valid !== 1'b0 || if_reg.data_out !== 64'h10F) begin
         errors++; $display("FAIL fill_idle_hold: got v=%b d=%h want v=0 d=10f",
                            if_reg.rd_valid, if_reg.data_out);
      end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (st_reg !== exp_status()) begin
         errors++; $display("FAIL fill_clr_status: got %b want %b", st_reg, exp_status());
      end
   endtask

   task automatic test_full_wrap();
      logic [DW-1:0] want;
      for (int i = 0; i < 16; i++) step(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 64'h300 + 64'(i), 1'b1, 1'b0);
         want = (i < 16) ? 64'h200 + 64'(i) : 64'h300 + 64'(i - 16);
         checks++;
         if (if_reg.count !== 5'd16 || if_reg.fifo_overflow !== 1'b0) begin
            errors++; $display("FAIL wrap_count[%0d]: got count=%0d ovf=%b want 16 0", i,
                               if_reg.count, if_reg.fifo_overflow);
         end
         checks++;
         if (if_reg.rd_valid !== 1'b1 || if_reg.data_out !== want) begin
            errors++; $display("FAIL wrap_data[%0d]: got v=%b d=%h want v=1 d=%h", i,
                               if_reg.rd_valid, if_reg.data_out, want);
         end
         checks++;
         if (if_ft.data_out !== q[0] || st_ft !== exp_status()) begin
            errors++; $display("FAIL wrap_ft[%0d]: got d=%h st=%b want d=%h st=%b", i,
                               if_ft.data_out, st_ft, q[0], exp_status());
         end
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         checks++;
         if (if_reg.data_out !== dout0_m || st_reg !== exp_status()) begin
            errors++; $display("FAIL wrap_drain[%0d]: got d=%h st=%b want d=%h st=%b", i,
                               if_reg.data_out, st_reg, dout0_m, exp_status());
         end
      end
   endtask

   task automatic test_underflow();
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (if_reg.fifo_underflow !== 1'b1 || if_reg.count !== 5'd0 || if_reg.rd_valid !== 1'b0) begin
         errors++; $display("FAIL unf_set: got unf=%b count=%0d v=%b want 1 0 0",
                            if_reg.fifo_underflow, if_reg.count, if_reg.rd_valid);
      end
      step(1'b0, '0, 1'b1, 1'b1);
      checks++;
      if (if_reg.fifo_underflow !== 1'b1 || if_ft.fifo_underflow !== 1'b1) begin
         errors++; $display("FAIL unf_set_wins: got reg=%b ft=%b want 1 1",
                            if_reg.fifo_underflow, if_ft.fifo_underflow);
      end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (if_reg.fifo_underflow !== 1'b0 || st_reg !== exp_status()) begin
         errors++; $display("FAIL unf_clear: got unf=%b st=%b want 0 st=%b",
                            if_reg.fifo_underflow, st_reg, exp_status());
      end
   endtask

   task automatic test_fwft();
      // The write is captured on this edge; the fall-through port shows it right after.
      step(1'b1, 64'hA5, 1'b0, 1'b0);
      checks++;
      if (if_ft.rd_valid !== 1'b1 || if_ft.data_out !== 64'hA5) begin
         errors++; $display("FAIL fwft_show: got v=%b d=%h want v=1 d=a5",
                            if_ft.rd_valid, if_ft.data_out);
      end
      checks++;
      if (if_reg.rd_valid !== 1'b0) begin
         errors++; $display("FAIL fwft_reg_quiet: got v=%b want 0", if_reg.rd_valid);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (if_ft.rd_valid !== 1'b0 || if_ft.fifo_empty !== 1'b1) begin
         errors++; $display("FAIL fwft_pop: got v=%b empty=%b want 0 1",
                            if_ft.rd_valid, if_ft.fifo_empty);
      end
      checks++;
      if (if_reg.rd_valid !== 1'b1 || if_reg.data_out !== 64'hA5) begin
         errors++; $display("FAIL fwft_reg_read: got v=%b d=%h want v=1 d=a5",
                            if_reg.rd_valid, if_reg.data_out);
      end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 9; i++) step(1'b1, 64'h400 + 64'(i), 1'b0, 1'b0);
      step(1'b1, 64'h500, 1'b1, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (st_reg !== exp_status() || st_ft !== exp_status()) begin
         errors++; $display("FAIL midrst_status: got reg=%b ft=%b want %b", st_reg, st_ft,
                            exp_status());
      end
      checks++;
      if (if_reg.rd_valid !== 1'b0 || if_reg.data_out !== 64'h0 || if_ft.rd_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_read: got v=%b d=%h vft=%b want 0 0 0",
                            if_reg.rd_valid, if_reg.data_out, if_ft.rd_valid);
      end
      #1 rst_n = 1'b1;
      step(1'b1, 64'h1, 1'b0, 1'b0);
      checks++;
      if (if_ft.data_out !== 64'h1 || if_reg.count !== 5'd1) begin
         errors++; $display("FAIL midrst_ft_new: got d=%h count=%0d want d=1 count=1",
                            if_ft.data_out, if_reg.count);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (if_reg.rd_valid !== 1'b1 || if_reg.data_out !== 64'h1) begin
         errors++; $display("FAIL midrst_reg_new: got v=%b d=%h want v=1 d=1",
                            if_reg.rd_valid, if_reg.data_out);
      end
   endtask

   task automatic test_random();
      int pw;
      int pr;
      for (int i = 0; i < 600; i++) begin
         // Alternate filling and draining phases so both boundaries are visited.
         pw = ((i / 100) % 2 == 1) ? 80 : 30;
         pr = ((i / 100) % 2 == 1) ? 30 : 80;
         step($urandom_range(0, 99) < pw, {$urandom, $urandom}, $urandom_range(0, 99) < pr,
              $urandom_range(0, 99) < 5);
         checks++;
         if (st_reg !== exp_status() || st_ft !== exp_status()) begin
            errors++; $display("FAIL rand_status[%0d]: got reg=%b ft=%b want %b", i, st_reg,
                               st_ft, exp_status());
         end
         checks++;
         if (if_reg.rd_valid !== vld0_m || if_reg.data_out !== dout0_m) begin
            errors++; $display("FAIL rand_reg_read[%0d]: got v=%b d=%h want v=%b d=%h", i,
                               if_reg.rd_valid, if_reg.data_out, vld0_m, dout0_m);
         end
         checks++;
         if (if_ft.rd_valid !== (q.size() != 0) ||
             (q.size() != 0 && if_ft.data_out !== q[0])) begin
            errors++; $display("FAIL rand_ft_read[%0d]: got v=%b d=%h want v=%b", i,
                               if_ft.rd_valid, if_ft.data_out, q.size() != 0);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      if_reg.wr = 1'b0; if_reg.rd = 1'b0; if_reg.flag_clr = 1'b0; if_reg.data_in = '0;
      if_ft.wr  = 1'b0; if_ft.rd  = 1'b0; if_ft.flag_clr  = 1'b0; if_ft.data_in  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_fill_overflow();
      test_full_wrap();
      test_underflow();
      test_fwft();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
